debug_run_ctrl: RTL and testbench
=================================

DEBUG_RUN_CTRL -- requirements
Module: debug_run_ctrl

Interface
REQ-001 Parameter PC_W, default 13, width of the fetch program counter.
REQ-002 Parameter NUM_BP, default 4, number of hardware breakpoint entries (>=1).
REQ-003 Parameter DEB_CYCLES, default 2097151, cycles the synchronised step button must stay high to count as pressed.
REQ-004 Parameter STEP_W, default 8, width of the step-count input.
REQ-005 clk  input  1  clock; all state on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 step_btn  input  1  raw, asynchronous step push-button.
REQ-008 finish_btn  input  1  raw, asynchronous leave-debug button.
REQ-009 pause  input  1  asynchronous level request to hold the core.
REQ-010 ebreak  input  1  EBREAK is in execute this cycle (synchronous, one cycle).
REQ-011 pc_fetch  input  PC_W  PC currently being fetched.
REQ-012 bp_wr_en  input  1  write one breakpoint entry this cycle.
REQ-013 bp_idx  input  max(1,$clog2(NUM_BP))  entry index for write; indices >= NUM_BP are ignored.
REQ-014 bp_addr  input  PC_W  breakpoint PC to store.
REQ-015 bp_valid  input  1  valid bit to store with bp_addr.
REQ-016 step_count  input  STEP_W  cycles released per step press; 0 is treated as 1.
REQ-017 halted  output  1  registered; core must freeze PC and pipeline registers while high.
REQ-018 debug_active  output  1  registered; high whenever the state is not RUN.
REQ-019 halt_reason  output  2  registered; 00 none, 01 ebreak, 10 breakpoint, 11 pause.
REQ-020 step_pulse  output  1  registered; one-cycle pulse per debounced step press.

Function
REQ-021 step_btn, finish_btn and pause SHALL each pass through a 2-flop synchroniser before any other use.
REQ-022 The debounce counter SHALL increment while synced step is high, saturate at DEB_CYCLES, and clear to 0 in the cycle synced step is low.
REQ-023 step_pulse SHALL be high for exactly one cycle, the cycle after the counter first reaches DEB_CYCLES; there is no further pulse until step is released and pressed again.
REQ-024 The finish event SHALL be the rising edge of synced finish_btn, one cycle wide.
REQ-025 A breakpoint hit SHALL occur when pc_fetch equals the bp_addr of any valid entry and the match mask is clear.
REQ-026 The breakpoint table SHALL be written synchronously; a same-cycle write and match SHALL use the old table contents.
REQ-027 The state machine SHALL have three states: RUN, HALT and STEP; halted=0 in RUN and STEP, and halted=1 in HALT.
REQ-028 From RUN, the state SHALL go to HALT on ebreak, breakpoint hit or synced pause, with priority ebreak > breakpoint > pause, and halt_reason SHALL be loaded accordingly.
REQ-029 From HALT, a finish event SHALL go to RUN and set halt_reason=00, unless synced pause is high, in which case the state stays HALT with reason 11.
REQ-030 From HALT, step_pulse SHALL go to STEP and load the step counter with max(step_count,1); finish SHALL take priority over a same-cycle step_pulse.
REQ-031 In STEP, the step counter SHALL decrement each cycle, and the state SHALL return to HALT (reason unchanged) in the cycle after the counter reads 1.
REQ-032 In STEP, ebreak, breakpoint hit or pause SHALL go to HALT immediately with the new reason; finish SHALL go to RUN; finish SHALL win over all others.
REQ-033 The match mask SHALL be set for exactly one cycle after any exit from HALT, so that resuming at a breakpoint PC does not re-trigger.
REQ-034 Latency: an event in cycle t SHALL make halted, debug_active and halt_reason change in cycle t+1.
REQ-035 In STEP with step_count=N, halted SHALL be low for exactly N consecutive cycles, absent other events.

Reset
REQ-036 While reset is high, the state SHALL be RUN; halted, debug_active, step_pulse=0; halt_reason=00.
REQ-037 While reset is high, all counters, synchronisers, the match mask and all bp valid bits SHALL be 0.
REQ-038 Reset asserted mid-STEP or mid-debounce SHALL abort immediately, with no residual step_pulse after release.

Verification (DEB_CYCLES=4, NUM_BP=4)
REQ-039 Pulse ebreak at cycle 10: halted=1 and halt_reason=01 at cycle 11; hold step_btn for 10 cycles with step_count=3: exactly one step_pulse, then halted low for exactly 3 cycles, then high again.
REQ-040 Write entry 2 = 0x0040 valid, then drive pc_fetch=0x0040 in RUN: halted=1 and reason=10 next cycle; after a finish press with pc_fetch still 0x0040: RUN, no re-halt.
REQ-041 Glitch step_btn high for 3 synced cycles, then low: no step_pulse and state stays HALT.
REQ-042 In HALT with pause held high, press finish: state stays HALT with reason=11; release pause, press finish: RUN with reason=00.
REQ-043 In STEP with step_count=0: exactly 1 released cycle; ebreak during an 8-cycle step: HALT next cycle with reason=01.
REQ-044 Assert reset mid-STEP: all outputs 0 at once; after release, no step_pulse and RUN.

Source files
------------

// File: rtl/debug_run_ctrl.sv
// debug_run_ctrl
// Run/halt/single-step controller for a simple in-order core's debug port.
// The core runs freely in RUN, freezes in HALT, and is released for a
// bounded number of cycles in STEP after each debounced step-button press.
//
// Ports:
//   clk          clock, all state on the rising edge
//   reset        asynchronous, active-high reset
//   step_btn     raw step push-button (asynchronous)
//   finish_btn   raw leave-debug button (asynchronous)
//   pause        asynchronous level request to hold the core
//   ebreak       EBREAK in execute this cycle (one cycle)
//   pc_fetch     PC currently being fetched
//   bp_wr_en     write one breakpoint entry this cycle
//   bp_idx       breakpoint entry index for the write
//   bp_addr      breakpoint PC to store
//   bp_valid     valid bit to store with bp_addr
//   step_count   cycles released per step press (0 behaves as 1)
//   halted       core must freeze PC and pipeline while high
//   debug_active high whenever the controller is not in RUN
//   halt_reason  00 none, 01 ebreak, 10 breakpoint, 11 pause
//   step_pulse   one-cycle pulse per debounced step press
module debug_run_ctrl #(
    parameter int unsigned PC_W       = 13,
    parameter int unsigned NUM_BP     = 4,
    parameter int unsigned DEB_CYCLES = 2097151,
    parameter int unsigned STEP_W     = 8,
    localparam int unsigned IDX_W     = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_btn,
    input  logic              finish_btn,
    input  logic              pause,
    input  logic              ebreak,
    input  logic [PC_W-1:0]   pc_fetch,
    input  logic              bp_wr_en,
    input  logic [IDX_W-1:0]  bp_idx,
    input  logic [PC_W-1:0]   bp_addr,
    input  logic              bp_valid,
    input  logic [STEP_W-1:0] step_count,
    output logic              halted,
    output logic              debug_active,
    output logic [1:0]        halt_reason,
    output logic              step_pulse
);

    localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {RUN, HALT, STEP} state_t;
    typedef enum logic [1:0] {R_NONE, R_EBREAK, R_BP, R_PAUSE} reason_t;

    state_t            state_q, state_n;
    reason_t           reason_q, reason_n;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_n;
    logic              match_mask;

    // Two-flop synchronisers; only bit [1] is used downstream.
    logic [1:0] step_sync, fin_sync, pause_sync;
    logic       step_s, fin_s, pause_s;
    logic       fin_prev, fin_evt;

    assign step_s  = step_sync[1];
    assign fin_s   = fin_sync[1];
    assign pause_s = pause_sync[1];
    assign fin_evt = fin_s & ~fin_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_sync  <= '0;
            fin_sync   <= '0;
            pause_sync <= '0;
            fin_prev   <= 1'b0;
        end else begin
            step_sync  <= {step_sync[0], step_btn};
            fin_sync   <= {fin_sync[0], finish_btn};
            pause_sync <= {pause_sync[0], pause};
            fin_prev   <= fin_s;
        end
    end

    // Debounce: the pulse fires the cycle after the counter first shows a
    // saturated value; deb_fired stays set while saturated, so holding the
    // button gives a single pulse.
    logic [DEB_W-1:0] deb_cnt;
    logic             deb_full, deb_fired;

    assign deb_full = (deb_cnt == DEB_W'(DEB_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_cnt    <= '0;
            deb_fired  <= 1'b0;
            step_pulse <= 1'b0;
        end else begin
            if (!step_s)
                deb_cnt <= '0;
            else if (!deb_full)
                deb_cnt <= deb_cnt + DEB_W'(1);
            deb_fired  <= deb_full;
            step_pulse <= deb_full & ~deb_fired;
        end
    end

    // Breakpoint table; match reads the registered contents, so a write
    // only takes effect from the following cycle.
    logic [PC_W-1:0]   bp_addr_q [NUM_BP];
    logic [NUM_BP-1:0] bp_valid_q;
    logic              bp_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bp_valid_q <= '0;
            for (int unsigned i = 0; i < NUM_BP; i++)
                bp_addr_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_BP; i++) begin
                if (bp_wr_en && bp_idx == IDX_W'(i)) begin
                    bp_addr_q[i]  <= bp_addr;
                    bp_valid_q[i] <= bp_valid;
                end
            end
        end
    end

    always_comb begin
        bp_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_BP; i++) begin
            if (bp_valid_q[i] && bp_addr_q[i] == pc_fetch)
                bp_hit = 1'b1;
        end
        if (match_mask)
            bp_hit = 1'b0;
    end

    always_comb begin
        state_n    = state_q;
        reason_n   = reason_q;
        step_cnt_n = step_cnt_q;
        unique case (state_q)
            RUN: begin
                if (ebreak) begin
                    state_n  = HALT;
                    reason_n = R_EBREAK;
                end else if (bp_hit) begin
                    state_n  = HALT;
                    reason_n = R_BP;
                end else if (pause_s) begin
                    state_n  = HALT;
                    reason_n = R_PAUSE;
                end
            end
            HALT: begin
                if (fin_evt) begin
                    if (pause_s) begin
                        reason_n = R_PAUSE;
                    end else begin
                        state_n  = RUN;
                        reason_n = R_NONE;
                    end
                end else if (step_pulse) begin
                    state_n    = STEP;
                    step_cnt_n = (step_count == '0) ? STEP_W'(1) : step_count;
                end
            end
            STEP: begin
                step_cnt_n = step_cnt_q - STEP_W'(1);
                if (fin_evt) begin
                    state_n  = RUN;
                    reason_n = R_NONE;
                end else if (ebreak) begin
                    state_n  = HALT;
                    reason_n = R_EBREAK;
                end else if (bp_hit) begin
                    state_n  = HALT;
                    reason_n = R_BP;
                end else if (pause_s) begin
                    state_n  = HALT;
                    reason_n = R_PAUSE;
                end else if (step_cnt_q == STEP_W'(1)) begin
                    state_n = HALT;
                end
            end
            default: begin
                state_n  = RUN;
                reason_n = R_NONE;
            end
        endcase
    end

    // Outputs are registered from the next-state value so they change in
    // the cycle directly after the causing event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            reason_q     <= R_NONE;
            step_cnt_q   <= '0;
            match_mask   <= 1'b0;
            halted       <= 1'b0;
            debug_active <= 1'b0;
        end else begin
            state_q      <= state_n;
            reason_q     <= reason_n;
            step_cnt_q   <= step_cnt_n;
            match_mask   <= (state_q == HALT) && (state_n != HALT);
            halted       <= (state_n == HALT);
            debug_active <= (state_n != RUN);
        end
    end

    assign halt_reason = reason_q;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Self-checking bench for debug_run_ctrl (DEB_CYCLES=4, NUM_BP=4).
module tb_debug_run_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        step_btn, finish_btn, pause, ebreak;
    logic [12:0] pc_fetch;
    logic        bp_wr_en;
    logic [1:0]  bp_idx;
    logic [12:0] bp_addr;
    logic        bp_valid;
    logic [7:0]  step_count;
    logic        halted, debug_active, step_pulse;
    logic [1:0]  halt_reason;

    int checks = 0;
    int errors = 0;

    debug_run_ctrl #(
        .PC_W(13), .NUM_BP(4), .DEB_CYCLES(4), .STEP_W(8)
    ) dut (
        .clk(clk), .reset(reset), .step_btn(step_btn), .finish_btn(finish_btn),
        .pause(pause), .ebreak(ebreak), .pc_fetch(pc_fetch), .bp_wr_en(bp_wr_en),
        .bp_idx(bp_idx), .bp_addr(bp_addr), .bp_valid(bp_valid),
        .step_count(step_count), .halted(halted), .debug_active(debug_active),
        .halt_reason(halt_reason), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    typedef struct {
        logic        eb, fin, pse, wr;
        logic [1:0]  idx;
        logic [12:0] addr;
        logic        val;
        logic [12:0] pc;
        logic        exp_h, exp_a;
        logic [1:0]  exp_r;
    } vec_t;

    function automatic vec_t mk(input logic eb, input logic fin, input logic pse,
                                input logic wr, input logic [1:0] idx,
                                input logic [12:0] addr, input logic val,
                                input logic [12:0] pc, input logic h,
                                input logic [1:0] r);
        vec_t v;
        v.eb = eb; v.fin = fin; v.pse = pse; v.wr = wr; v.idx = idx;
        v.addr = addr; v.val = val; v.pc = pc;
        v.exp_h = h; v.exp_a = h; v.exp_r = r;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives step_btn high for btn_cycles, samples every cycle.
    task automatic run_window(input int n, input int btn_cycles,
                              output int pulses, output int lows,
                              output int runs, output int act_lows);
        logic prev_h;
        prev_h = halted;
        pulses = 0; lows = 0; runs = 0; act_lows = 0;
        for (int i = 0; i < n; i++) begin
            step_btn = (i < btn_cycles);
            @(negedge clk);
            if (step_pulse) pulses++;
            if (!halted) lows++;
            if (!halted && prev_h) runs++;
            if (!debug_active) act_lows++;
            prev_h = halted;
        end
        step_btn = 1'b0;
    endtask

    vec_t vecs[36];
    int   p, l, r, al;
    logic found;

    initial begin
        vecs[0]  = mk(0,0,0, 0,0,13'h000,0, 13'h000, 0,2'd0);
        vecs[1]  = mk(0,0,0, 1,2,13'h040,1, 13'h040, 0,2'd0);
        vecs[2]  = mk(0,0,0, 0,0,13'h000,0, 13'h040, 1,2'd2);
        vecs[3]  = mk(0,0,0, 0,0,13'h000,0, 13'h040, 1,2'd2);
        vecs[4]  = mk(1,0,0, 0,0,13'h000,0, 13'h040, 1,2'd2);
        vecs[5]  = mk(0,1,0, 0,0,13'h000,0, 13'h040, 1,2'd2);
        vecs[6]  = mk(0,1,0, 0,0,13'h000,0, 13'h040, 1,2'd2);
        vecs[7]  = mk(0,1,0, 0,0,13'h000,0, 13'h040, 0,2'd0);
        vecs[8]  = mk(0,1,0, 0,0,13'h000,0, 13'h040, 0,2'd0);
        vecs[9]  = mk(0,0,0, 0,0,13'h000,0, 13'h044, 0,2'd0);
        vecs[10] = mk(1,0,0, 0,0,13'h000,0, 13'h044, 1,2'd1);
        vecs[11] = mk(0,1,0, 0,0,13'h000,0, 13'h044, 1,2'd1);
        vecs[12] = mk(0,1,0, 0,0,13'h000,0, 13'h044, 1,2'd1);
        vecs[13] = mk(0,1,0, 0,0,13'h000,0, 13'h044, 0,2'd0);
        vecs[14] = mk(0,0,0, 0,0,13'h000,0, 13'h044, 0,2'd0);
        vecs[15] = mk(1,0,0, 0,0,13'h000,0, 13'h040, 1,2'd1);
        vecs[16] = mk(0,0,0, 0,0,13'h000,0, 13'h000, 1,2'd1);
        vecs[17] = mk(0,1,0, 0,0,13'h000,0, 13'h000, 1,2'd1);
        vecs[18] = mk(0,1,0, 0,0,13'h000,0, 13'h000, 1,2'd1);
        vecs[19] = mk(0,1,0, 0,0,13'h000,0, 13'h000, 0,2'd0);
        vecs[20] = mk(0,1,0, 0,0,13'h000,0, 13'h040, 0,2'd0);
        vecs[21] = mk(0,0,0, 1,2,13'h040,0, 13'h044, 0,2'd0);
        vecs[22] = mk(0,0,0, 0,0,13'h000,0, 13'h040, 0,2'd0);
        vecs[23] = mk(0,0,1, 0,0,13'h000,0, 13'h040, 0,2'd0);
        vecs[24] = mk(0,0,1, 0,0,13'h000,0, 13'h000, 0,2'd0);
        vecs[25] = mk(0,0,1, 0,0,13'h000,0, 13'h000, 1,2'd3);
        vecs[26] = mk(0,1,1, 0,0,13'h000,0, 13'h000, 1,2'd3);
        vecs[27] = mk(0,1,1, 0,0,13'h000,0, 13'h000, 1,2'd3);
        vecs[28] = mk(0,1,1, 0,0,13'h000,0, 13'h000, 1,2'd3);
        vecs[29] = mk(0,1,1, 0,0,13'h000,0, 13'h000, 1,2'd3);
        vecs[30] = mk(0,0,0, 0,0,13'h000,0, 13'h000, 1,2'd3);
        vecs[31] = mk(0,0,0, 0,0,13'h000,0, 13'h000, 1,2'd3);
        vecs[32] = mk(0,1,0, 0,0,13'h000,0, 13'h000, 1,2'd3);
        vecs[33] = mk(0,1,0, 0,0,13'h000,0, 13'h000, 1,2'd3);
        vecs[34] = mk(0,1,0, 0,0,13'h000,0, 13'h000, 0,2'd0);
        vecs[35] = mk(0,0,0, 0,0,13'h000,0, 13'h000, 0,2'd0);

        reset = 1'b1; step_btn = 0; finish_btn = 0; pause = 0; ebreak = 0;
        pc_fetch = '0; bp_wr_en = 0; bp_idx = '0; bp_addr = '0; bp_valid = 0;
        step_count = 8'd1;
        repeat (3) @(negedge clk);
        check("rst_halted", 16'(halted), 16'h0);
        check("rst_active", 16'(debug_active), 16'h0);
        check("rst_reason", 16'(halt_reason), 16'h0);
        check("rst_pulse", 16'(step_pulse), 16'h0);
        reset = 1'b0;

        // Table: one row per cycle, checked after the edge consuming it.
        for (int i = 0; i < 36; i++) begin
            ebreak = vecs[i].eb; finish_btn = vecs[i].fin; pause = vecs[i].pse;
            bp_wr_en = vecs[i].wr; bp_idx = vecs[i].idx; bp_addr = vecs[i].addr;
            bp_valid = vecs[i].val; pc_fetch = vecs[i].pc;
            @(negedge clk);
            check($sformatf("vec%0d_halted", i), 16'(halted), 16'(vecs[i].exp_h));
            check($sformatf("vec%0d_active", i), 16'(debug_active), 16'(vecs[i].exp_a));
            check($sformatf("vec%0d_reason", i), 16'(halt_reason), 16'(vecs[i].exp_r));
            check($sformatf("vec%0d_pulse", i), 16'(step_pulse), 16'h0);
        end
        ebreak = 0; finish_btn = 0; pause = 0; bp_wr_en = 0; pc_fetch = '0;

        // Ebreak at cycle 10, then a held step press with step_count=3.
        repeat (9) @(negedge clk);
        check("a_pre_halted", 16'(halted), 16'h0);
        ebreak = 1'b1;
        @(negedge clk);
        ebreak = 1'b0;
        check("a_ebreak_halted", 16'(halted), 16'h1);
        check("a_ebreak_reason", 16'(halt_reason), 16'h1);
        step_count = 8'd3;
        run_window(30, 10, p, l, r, al);
        check("a_step_pulses", 16'(p), 16'd1);
        check("a_step_low_cycles", 16'(l), 16'd3);
        check("a_step_low_runs", 16'(r), 16'd1);
        check("a_step_active_low", 16'(al), 16'd0);
        check("a_after_halted", 16'(halted), 16'h1);
        check("a_after_reason", 16'(halt_reason), 16'h1);

        // Glitch of 3 synced cycles: below the debounce threshold.
        run_window(15, 3, p, l, r, al);
        check("b_glitch_pulses", 16'(p), 16'd0);
        check("b_glitch_lows", 16'(l), 16'd0);

        // Exactly 4 synced cycles with step_count=0: one released cycle.
        step_count = 8'd0;
        run_window(20, 4, p, l, r, al);
        check("c_cnt0_pulses", 16'(p), 16'd1);
        check("c_cnt0_lows", 16'(l), 16'd1);
        check("c_cnt0_halted", 16'(halted), 16'h1);

        // Leave debug, halt on a breakpoint, then ebreak mid 8-cycle step.
        finish_btn = 1'b1;
        repeat (4) @(negedge clk);
        finish_btn = 1'b0;
        repeat (3) @(negedge clk);
        check("c_finish_halted", 16'(halted), 16'h0);
        check("c_finish_reason", 16'(halt_reason), 16'h0);
        bp_wr_en = 1'b1; bp_idx = 2'd0; bp_addr = 13'h100; bp_valid = 1'b1;
        @(negedge clk);
        bp_wr_en = 1'b0; pc_fetch = 13'h100;
        @(negedge clk);
        check("c_bp_halted", 16'(halted), 16'h1);
        check("c_bp_reason", 16'(halt_reason), 16'h2);
        pc_fetch = 13'h104;
        step_count = 8'd8;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            step_btn = (k < 10);
            @(negedge clk);
            if (!halted) found = 1'b1;
        end
        step_btn = 1'b0;
        check("c_step_entered", 16'(found), 16'h1);
        repeat (2) begin
            @(negedge clk);
            check("c_step_still_low", 16'(halted), 16'h0);
        end
        ebreak = 1'b1;
        @(negedge clk);
        ebreak = 1'b0;
        check("c_eb_step_halted", 16'(halted), 16'h1);
        check("c_eb_step_reason", 16'(halt_reason), 16'h1);
        run_window(15, 0, p, l, r, al);
        check("c_eb_no_pulse", 16'(p), 16'd0);
        check("c_eb_stay_halt", 16'(l), 16'd0);

        // Reset asserted in the middle of STEP with the button still held.
        found = 1'b0;
        step_btn = 1'b1;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (!halted) found = 1'b1;
        end
        check("d_step_entered", 16'(found), 16'h1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("d_rst_halted", 16'(halted), 16'h0);
        check("d_rst_active", 16'(debug_active), 16'h0);
        check("d_rst_reason", 16'(halt_reason), 16'h0);
        check("d_rst_pulse", 16'(step_pulse), 16'h0);
        @(negedge clk);
        step_btn = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_window(15, 0, p, l, r, al);
        check("d_post_pulses", 16'(p), 16'd0);
        check("d_post_run_lows", 16'(l), 16'd15);
        check("d_post_active_low", 16'(al), 16'd15);
        check("d_post_reason", 16'(halt_reason), 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
